// File: rtl/load_store_unit_pkg.sv
// lsu_pkg: funct3 encodings and FSM state type shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: word-addressed req/ready data memory port with byte enables
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  modport master (output req, we, addr, be, wdata, input rdata, ready);
  modport slave  (input req, we, addr, be, wdata, output rdata, ready);
endinterface

// File: rtl/load_store_unit_load_aligner.sv
// load_aligner: selects the addressed lane of a read word and sign/zero-extends it
module load_aligner
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  logic [31:0] w_s;
  always_comb begin
    w_s    = i_rdata >> {i_off, 3'b000};
    o_data = i_funct3 == F3_B  ? {{24{w_s[7]}}, w_s[7:0]} :
             i_funct3 == F3_BU ? {24'b0, w_s[7:0]} :
             i_funct3 == F3_H  ? {{16{w_s[15]}}, w_s[15:0]} :
             i_funct3 == F3_HU ? {16'b0, w_s[15:0]} : w_s;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle memory stage stalling the datapath around a variable-latency memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  load_store_unit_if.master mem
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  lsu_state_t  r_state, w_next;
  logic        r_req, r_we, r_to;
  logic [29:0] r_addr;
  logic [3:0]  r_be, w_be;
  logic [31:0] r_wdata, w_wdata, w_ext;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [CW-1:0] r_cnt;
  logic        w_access, w_illegal, w_go, w_to, w_stall, w_fault;
  assign mem.req   = r_req;
  assign mem.we    = r_we;
  assign mem.addr  = {r_addr, 2'b00};
  assign mem.be    = r_be;
  assign mem.wdata = r_wdata;
  assign w_access  = MemRead || MemWrite;
  assign w_illegal = (MemRead && MemWrite) || (MemWrite && funct3[2]) || funct3 == 3'b011 ||
                     funct3[2:1] == 2'b11 || (funct3[1:0] == 2'b01 && Addr[0]) ||
                     (funct3 == F3_W && Addr[1:0] != 2'b00);
  assign w_go      = w_access && !w_illegal;
  assign w_be      = funct3[1:0] == 2'b00 ? 4'b0001 << Addr[1:0] :
                     funct3[1:0] == 2'b01 ? 4'b0011 << Addr[1:0] : 4'hF;
  assign w_wdata   = funct3[1:0] == 2'b00 ? {4{WriteData[7:0]}} :
                     funct3[1:0] == 2'b01 ? {2{WriteData[15:0]}} : WriteData;
  // A ready arriving on the final allowed cycle still wins over the timeout
  assign w_to      = TIMEOUT_CYCLES != 0 && r_cnt == CW'(TIMEOUT_CYCLES - 1) && !mem.ready;
  assign Stall     = rst && w_stall;
  assign Fault     = rst && w_fault;
  load_aligner u_align (.i_rdata(mem.rdata), .i_off(r_off), .i_funct3(r_f3), .o_data(w_ext));
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_fault = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_go;
        w_fault = w_access && w_illegal;
        w_next  = w_go ? BUSY : IDLE;
      end
      BUSY: begin
        w_stall = 1'b1;
        w_next  = (mem.ready || w_to) ? DONE : BUSY;
      end
      default: begin
        w_fault = r_to;
        w_next  = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_to     <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_f3     <= '0;
      r_off    <= '0;
      r_cnt    <= '0;
      ReadData <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_go) begin
          r_req   <= 1'b1;
          r_we    <= MemWrite;
          r_addr  <= Addr[31:2];
          r_be    <= w_be;
          r_wdata <= w_wdata;
          r_f3    <= funct3;
          r_off   <= Addr[1:0];
          r_cnt   <= '0;
          r_to    <= 1'b0;
        end
        BUSY: begin
          r_cnt <= r_cnt + CW'(1);
          if (mem.ready) begin
            r_req <= 1'b0;
            if (!r_we) ReadData <= w_ext;
          end else if (w_to) begin
            r_req    <= 1'b0;
            r_to     <= 1'b1;
            ReadData <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
